shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_pkg.sv | 15 +
 rtl/shift_bit_counter.sv | 37 +++
 rtl/shift_sequencer.sv | 101 ++++++++++
 tb/tb_shift_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: state encoding and
// default geometry of the controlled register.
package shift_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int DEFAULT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Shift-cycle counter: cleared when a transfer is loaded, counts qualified
// shift cycles and flags the last one. It wraps back to zero on the
// terminal cycle so it never holds a value above WIDTH-1.
module shift_bit_counter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_reg;

    // Count register: synchronous clear on load, increment (with wrap) on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (enable) begin
            if (terminal) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Terminal count marks the final shift cycle of a word.
    always_comb begin
        terminal = (count_reg == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for a right shift register used as a parallel-to-serial
// transmitter. A word accepted in IDLE is preset into the register, then
// exactly WIDTH right shifts are qualified while the register's LSB is
// presented as an LSB-first serial stream. All control outputs are decoded
// from registered state; only the fill bit and serial bit pass through
// combinationally from rotate/fillBit/regOut while shifting.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic             rotate,
    input  logic             fillBit,
    input  logic [WIDTH-1:0] regOut,
    output logic             enablePreset,
    output logic [WIDTH-1:0] preset,
    output logic             shiftEnable,
    output logic             serialInput,
    output logic             serialOut,
    output logic             serialValid,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] word_reg;
    logic             last_bit;

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clockpulse),
        .rst_n    (clear),
        .load     (state_reg == LOAD),
        .enable   (state_reg == SHIFT),
        .terminal (last_bit)
    );

    // State and captured word; the word only changes when a start is accepted.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                word_reg <= word;
            end
        end
    end

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from registered state; serial bits are gated to SHIFT.
    always_comb begin
        enablePreset = 1'b0;
        shiftEnable  = 1'b0;
        serialValid  = 1'b0;
        serialOut    = 1'b0;
        serialInput  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        preset       = word_reg;
        case (state_reg)
            LOAD: begin
                enablePreset = 1'b1;
                busy         = 1'b1;
            end
            SHIFT: begin
                shiftEnable = 1'b1;
                serialValid = 1'b1;
                busy        = 1'b1;
                serialOut   = regOut[0];
                serialInput = rotate ? regOut[0] : fillBit;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer paired with a behavioural right shift register.
// Expected streams come from the word itself (bit i of the word is the i-th
// serial bit) and the final register contents from the fill rule.
module tb_shift_sequencer;

    localparam int W = 6;

    logic         clockpulse = 1'b0;
    logic         clear;
    logic         start;
    logic [W-1:0] word;
    logic         rotate;
    logic         fillBit;
    logic [W-1:0] regOut;
    logic         enablePreset;
    logic [W-1:0] preset;
    logic         shiftEnable;
    logic         serialInput;
    logic         serialOut;
    logic         serialValid;
    logic         busy;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] shreg = '0;

    shift_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
        .clockpulse   (clockpulse),
        .clear        (clear),
        .start        (start),
        .word         (word),
        .rotate       (rotate),
        .fillBit      (fillBit),
        .regOut       (regOut),
        .enablePreset (enablePreset),
        .preset       (preset),
        .shiftEnable  (shiftEnable),
        .serialInput  (serialInput),
        .serialOut    (serialOut),
        .serialValid  (serialValid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clockpulse = ~clockpulse;

    // Behavioural shift register: preset load has priority, else right shift.
    always_ff @(posedge clockpulse) begin
        if (enablePreset)
            shreg <= preset;
        else if (shiftEnable)
            shreg <= {serialInput, shreg[W-1:1]};
    end
    assign regOut = shreg;

    task automatic tick();
        @(posedge clockpulse);
        #1;
    endtask

    // One full transaction from IDLE, checked cycle by cycle.
    task automatic test_transmission(input logic [W-1:0] w, input logic r, input logic f);
        logic [W-1:0] final_reg;
        logic [6:0]   got;
        logic [6:0]   exp;
        final_reg = r ? w : {W{f}};
        word = w; rotate = r; fillBit = f; start = 1'b1;
        tick();
        start = 1'b0; word = W'($urandom);
        vectors++;
        if ({enablePreset, shiftEnable, serialValid, busy, done} !== 5'b10010) begin
            miscompares++;
            $display("FAIL load_ctrl word=%b got=%b exp=10010", w,
                     {enablePreset, shiftEnable, serialValid, busy, done});
        end
        tick();
        for (int i = 0; i < W; i++) begin
            got = {enablePreset, shiftEnable, serialValid, busy, done, serialOut, serialInput};
            exp = {5'b01110, w[i], (r ? w[i] : f)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL shift_bit%0d word=%b rot=%b fill=%b got=%b exp=%b", i, w, r, f, got, exp);
            end
            tick();
        end
        vectors++;
        if ({enablePreset, shiftEnable, serialValid, busy, done} !== 5'b00011 ||
            regOut !== final_reg || preset !== w) begin
            miscompares++;
            $display("FAIL done_state word=%b ctrl=%b regOut=%b exp_regOut=%b preset=%b",
                     w, {enablePreset, shiftEnable, serialValid, busy, done}, regOut, final_reg, preset);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || preset !== w) begin
            miscompares++;
            $display("FAIL idle_after word=%b busy=%b done=%b preset=%b", w, busy, done, preset);
        end
        $display("tx word=%b rotate=%b fill=%b final=%b", w, r, f, regOut);
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        clear = 1'b0; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            word = W'($urandom); rotate = 1'($urandom); fillBit = 1'($urandom);
            tick();
            outs = {enablePreset, shiftEnable, serialValid, busy, done,
                    serialInput, serialOut, preset, 2'b00};
            vectors++;
            if (outs !== 15'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle=%0d got=%b exp=0", c, outs);
            end
        end
        start = 1'b0; clear = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || enablePreset !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release_idle cycle=%0d busy=%b ep=%b done=%b", c, busy, enablePreset, done);
            end
        end
        $display("reset checked");
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        w1 = W'($urandom); w2 = ~w1;
        word = w1; rotate = 1'b0; fillBit = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (serialOut !== w1[i] || serialValid !== 1'b1 || preset !== w1) begin
                miscompares++;
                $display("FAIL busy_ignore bit%0d got=%b exp=%b preset=%b", i, serialOut, w1[i], preset);
            end
            start = (i == 1); word = w2;
            tick();
        end
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || preset !== w1) begin
            miscompares++;
            $display("FAIL busy_ignore_done done=%b preset=%b exp=%b", done, preset, w1);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_noqueue busy=%b exp=0", busy);
        end
        $display("busy ignore word=%b extra=%b", w1, w2);
    endtask

    task automatic test_back_to_back();
        int last_done;
        int pulses;
        last_done = -1; pulses = 0;
        rotate = 1'b0; fillBit = 1'b0; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            word = W'($urandom);
            tick();
            if (done === 1'b1) begin
                if (last_done >= 0) begin
                    vectors++;
                    if (c - last_done != 9) begin
                        miscompares++;
                        $display("FAIL b2b_period got=%0d exp=9", c - last_done);
                    end
                end
                last_done = c;
                pulses++;
            end
        end
        start = 1'b0;
        vectors++;
        if (pulses < 4) begin
            miscompares++;
            $display("FAIL b2b_pulses got=%0d exp>=4", pulses);
        end
        for (int c = 0; c < 12 && busy === 1'b1; c++) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain busy=%b exp=0", busy);
        end
        $display("back to back pulses=%0d", pulses);
    endtask

    task automatic test_reset_midshift();
        logic [13:0] outs;
        word = 6'b110110; rotate = 1'b0; fillBit = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 clear = 1'b0;
        #1;
        outs = {enablePreset, shiftEnable, serialValid, busy, done, serialInput, serialOut, preset, 1'b0};
        vectors++;
        if (outs !== 14'd0) begin
            miscompares++;
            $display("FAIL midshift_clear got=%b exp=0", outs);
        end
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midshift_hold done=%b busy=%b", done, busy);
            end
        end
        start = 1'b0; clear = 1'b1;
        tick();
        test_transmission(6'b010101, 1'b0, 1'b0);
        $display("reset mid-shift checked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0; start = 1'b0; word = '0; rotate = 1'b0; fillBit = 1'b0;
        test_reset();
        test_transmission(6'b110000, 1'b0, 1'b0);
        test_transmission(6'b101100, 1'b1, 1'b0);
        test_transmission(6'b000001, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            test_transmission(W'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end
        test_busy_ignore();
        test_back_to_back();
        test_reset_midshift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
